access_queue: RTL and testbench

//  Output buffer behind the access scheduler tree. Each cycle the tree flags a winner
//  (active) and presents its request word; this block captures it in order and replays
//  it to the memory/interconnect port over a valid/ready handshake.
//  - stall is driven back to all requesters so no grant is issued while the queue is full.
//  - overflow is a sticky error flag for any request that arrives while stalled.

---
 rtl/access_queue.sv | 97 +++++++++
 tb/tb_access_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/access_queue.sv
// Output buffer behind the access scheduler: captures winning request words in order
// and replays them to the memory port over a valid/ready handshake.
module access_queue #(
  parameter  int DATA_WIDTH = 132,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_active,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  occ_t                  state;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count_next;
  occ_t                  state_next;

  // stall and out_valid come only from the registered occupancy state, so neither
  // out_ready nor in_active can reach stall combinationally.
  assign stall     = (state == FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = mem[rd_ptr];

  assign push = in_active & ~stall;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    state_next = PARTIAL;
    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == CW'(DEPTH)) begin
      state_next = FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_active && stall) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  occupancy_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  state_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
    ((count == '0) == (state == EMPTY)) && ((count == CW'(DEPTH)) == (state == FULL)));

endmodule

// File: tb/tb_access_queue.sv
// Self-checking bench for access_queue: directed vector table for the corner cases,
// then randomized traffic against a queue-based reference model.
module tb_access_queue;

  localparam int DW    = 132;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          in_active;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;

  int checks;
  int passes;

  logic [DW-1:0] model_q[$];
  logic          model_ovf;
  int            accepted;

  access_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_active (in_active),
    .in_data   (in_data),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          act;
    logic [DW-1:0] data;
    logic          rdy;
    int            exp_count;
    logic          exp_valid;
    logic          exp_stall;
    logic          exp_ovf;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic act, int data, logic rdy, int c, logic v, logic s,
                              logic o, int d);
    vec_t r;
    r.act       = act;
    r.data      = DW'(data);
    r.rdy       = rdy;
    r.exp_count = c;
    r.exp_valid = v;
    r.exp_stall = s;
    r.exp_ovf   = o;
    r.exp_data  = DW'(d);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge, results sampled at next negedge.
  task automatic applyStimulus(input logic act, input logic [DW-1:0] data, input logic rdy);
    logic full_m;
    logic pop_m;
    in_active = act;
    in_data   = data;
    out_ready = rdy;
    @(posedge clk);
    full_m = (model_q.size() == DEPTH);
    pop_m  = (model_q.size() != 0) && rdy;
    if (act && full_m) model_ovf = 1'b1;
    if (pop_m) void'(model_q.pop_front());
    if (act && !full_m) begin
      model_q.push_back(data);
      accepted++;
    end
    @(negedge clk);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_count"}, DW'(count), DW'(model_q.size()));
    checkOutput({tag, "_valid"}, DW'(out_valid), DW'(model_q.size() != 0));
    checkOutput({tag, "_stall"}, DW'(stall), DW'(model_q.size() == DEPTH));
    checkOutput({tag, "_ovf"}, DW'(overflow), DW'(model_ovf));
    if (model_q.size() != 0) checkOutput({tag, "_data"}, out_data, model_q[0]);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_count"}, DW'(count), '0);
    checkOutput({tag, "_valid"}, DW'(out_valid), '0);
    checkOutput({tag, "_stall"}, DW'(stall), '0);
    checkOutput({tag, "_ovf"}, DW'(overflow), '0);
  endtask

  task automatic doReset();
    in_active = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset_held");
    rst_n = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    checkIdle("reset_release");
  endtask

  initial begin
    int cycles;
    checks    = 0;
    passes    = 0;
    accepted  = 0;
    model_ovf = 1'b0;
    rst_n     = 1'b1;
    in_active = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Latency, fill/overflow/drain, concurrent push-pop, full with pop.
    vecs[0]  = mk(1, 'h5,  0, 1, 1, 0, 0, 'h5);
    vecs[1]  = mk(0, 'h0,  1, 0, 0, 0, 0, 'h0);
    vecs[2]  = mk(1, 'h1,  0, 1, 1, 0, 0, 'h1);
    vecs[3]  = mk(1, 'h2,  0, 2, 1, 0, 0, 'h1);
    vecs[4]  = mk(1, 'h3,  0, 3, 1, 0, 0, 'h1);
    vecs[5]  = mk(1, 'h4,  0, 4, 1, 1, 0, 'h1);
    vecs[6]  = mk(1, 'h6,  0, 4, 1, 1, 1, 'h1);
    vecs[7]  = mk(0, 'h0,  1, 3, 1, 0, 1, 'h2);
    vecs[8]  = mk(0, 'h0,  1, 2, 1, 0, 1, 'h3);
    vecs[9]  = mk(0, 'h0,  1, 1, 1, 0, 1, 'h4);
    vecs[10] = mk(0, 'h0,  1, 0, 0, 0, 1, 'h0);
    vecs[11] = mk(1, 'hA,  0, 1, 1, 0, 1, 'hA);
    vecs[12] = mk(1, 'hB,  0, 2, 1, 0, 1, 'hA);
    vecs[13] = mk(1, 'hC,  1, 2, 1, 0, 1, 'hB);
    vecs[14] = mk(0, 'h0,  1, 1, 1, 0, 1, 'hC);
    vecs[15] = mk(0, 'h0,  1, 0, 0, 0, 1, 'h0);
    vecs[16] = mk(1, 'h11, 0, 1, 1, 0, 1, 'h11);
    vecs[17] = mk(1, 'h12, 0, 2, 1, 0, 1, 'h11);
    vecs[18] = mk(1, 'h13, 0, 3, 1, 0, 1, 'h11);
    vecs[19] = mk(1, 'h14, 0, 4, 1, 1, 1, 'h11);
    vecs[20] = mk(1, 'h15, 1, 3, 1, 0, 1, 'h12);
    vecs[21] = mk(0, 'h0,  1, 2, 1, 0, 1, 'h13);
    vecs[22] = mk(0, 'h0,  1, 1, 1, 0, 1, 'h14);
    vecs[23] = mk(0, 'h0,  1, 0, 0, 0, 1, 'h0);

    @(negedge clk);
    doReset();

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].act, vecs[i].data, vecs[i].rdy);
      checkOutput({tag, "_count"}, DW'(count), DW'(vecs[i].exp_count));
      checkOutput({tag, "_valid"}, DW'(out_valid), DW'(vecs[i].exp_valid));
      checkOutput({tag, "_stall"}, DW'(stall), DW'(vecs[i].exp_stall));
      checkOutput({tag, "_ovf"}, DW'(overflow), DW'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) checkOutput({tag, "_data"}, out_data, vecs[i].exp_data);
    end

    // Randomized traffic against the reference queue, with an async reset pulse mid-run.
    doReset();
    accepted = 0;
    cycles   = 0;
    while (accepted < 32 && cycles < 600) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_word(), 1'($urandom_range(0, 1)));
      checkModel($sformatf("rnd%0d", cycles));
      if (cycles == 20) begin
        in_active = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkIdle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        checkModel("post_reset");
      end
      cycles++;
    end
    checkOutput("random_budget", DW'(accepted >= 32), DW'(1));

    // Drain whatever is left and confirm order to the end.
    cycles = 0;
    while (model_q.size() != 0 && cycles < 20) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkModel("drain");
      cycles++;
    end
    checkOutput("drain_budget", DW'(model_q.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
